letter_typewriter: RTL and testbench

- Consumer-side counterpart of the menu letter sources: takes a 10-entry array of 5-bit letter codes and reveals it to the text drawer one letter per programmable delay (typewriter effect).
- Snapshots the letter array on start and drives a display-ready array in which unrevealed positions hold a blank code.
- Reports progress through busy/done/reveal-count status and a per-letter pulse, used by the game-menu sound and flow control.

---
 rtl/letter_typewriter.sv | 143 ++++++++++++++
 tb/tb_letter_typewriter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/letter_typewriter.sv
// letter_typewriter: snapshots a letter array on start and reveals it to the
// text drawer one position per CHAR_DELAY cycles (typewriter effect).
// Unrevealed positions show BLANK_CODE. Status: busy, done, revealed_cnt and a
// one-cycle new_letter pulse per timed reveal.
//
// Control inputs are single-cycle level samples at each rising clk edge (no
// handshake). Priority: resetN > clear > skip > start > timed reveal.
// o_dbg_state exposes the FSM state: 0 = IDLE, 1 = TYPING, 2 = DONE.
module letter_typewriter #(
  parameter int          NUM_LETTERS = 10,
  parameter int          CHAR_DELAY  = 2_500_000,
  parameter logic [4:0]  BLANK_CODE  = 5'd31
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         start,
  input  logic                         skip,
  input  logic                         clear,
  input  logic [NUM_LETTERS-1:0][4:0]  letters_in,
  output logic [NUM_LETTERS-1:0][4:0]  letters_out,
  output logic [3:0]                   revealed_cnt,
  output logic                         new_letter,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TYPING = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Timer only counts 0..CHAR_DELAY-1, so it never needs more bits than that.
  localparam int               TW       = (CHAR_DELAY > 1) ? $clog2(CHAR_DELAY) : 1;
  localparam logic [TW-1:0]    TMAX     = TW'(CHAR_DELAY - 1);
  localparam logic [3:0]       CNT_FULL = 4'(NUM_LETTERS);

  state_t                        r_state;
  logic [TW-1:0]                 r_timer;
  logic [3:0]                    r_cnt;
  logic [NUM_LETTERS-1:0][4:0]   r_shadow;
  logic [NUM_LETTERS-1:0][4:0]   r_letters;
  logic                          r_new;
  logic                          r_busy;
  logic                          r_done;

  state_t                        w_state;
  logic [TW-1:0]                 w_timer;
  logic [3:0]                    w_cnt;
  logic [NUM_LETTERS-1:0][4:0]   w_shadow;
  logic [NUM_LETTERS-1:0][4:0]   w_letters;
  logic                          w_new;
  logic                          w_busy;
  logic                          w_done;

  // Next-state and next-output logic; every value defaults to "hold".
  always_comb begin
    w_state   = r_state;
    w_timer   = r_timer;
    w_cnt     = r_cnt;
    w_shadow  = r_shadow;
    w_letters = r_letters;
    w_new     = 1'b0;

    if (clear) begin
      // Back to IDLE with blank display; the shadow copy is kept.
      w_state = S_IDLE;
      w_timer = '0;
      w_cnt   = '0;
      for (int i = 0; i < NUM_LETTERS; i++) w_letters[i] = BLANK_CODE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state  = S_TYPING;
            w_timer  = '0;
            w_cnt    = '0;
            w_shadow = letters_in;
            for (int i = 0; i < NUM_LETTERS; i++) w_letters[i] = BLANK_CODE;
          end
        end
        S_TYPING: begin
          if (skip) begin
            // Reveal every remaining position at once; no pulse for this.
            for (int i = 0; i < NUM_LETTERS; i++) begin
              if (4'(i) >= r_cnt) w_letters[i] = r_shadow[i];
            end
            w_cnt   = CNT_FULL;
            w_state = S_DONE;
          end else if (r_timer == TMAX) begin
            w_timer = '0;
            for (int i = 0; i < NUM_LETTERS; i++) begin
              if (4'(i) == r_cnt) w_letters[i] = r_shadow[i];
            end
            w_cnt = r_cnt + 4'd1;
            w_new = 1'b1;
            if (r_cnt + 4'd1 == CNT_FULL) w_state = S_DONE;
          end else begin
            w_timer = r_timer + 1'b1;
          end
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end

    w_busy = (w_state == S_TYPING);
    w_done = (w_state == S_DONE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (resetN) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      for (int i = 0; i < NUM_LETTERS; i++) r_letters[i] <= BLANK_CODE;
      r_new    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_timer   <= w_timer;
      r_cnt     <= w_cnt;
      r_shadow  <= w_shadow;
      r_letters <= w_letters;
      r_new     <= w_new;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign letters_out  = r_letters;
  assign revealed_cnt = r_cnt;
  assign new_letter   = r_new;
  assign busy         = r_busy;
  assign done         = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_letter_typewriter.sv
// Bench for letter_typewriter: two builds (CHAR_DELAY=4 and CHAR_DELAY=1) share
// the stimulus. A cycle-level reference model derived from elapsed time since
// start checks both every cycle; a vector table and a hand sequence cover the
// directed corner cases.
module tb_letter_typewriter;

  localparam int N = 10;

  // ---------------- clock / reset / DUTs ----------------
  logic clk;
  logic resetN, start, skip, clear;
  logic [N-1:0][4:0] letters_in;

  logic [N-1:0][4:0] lo_a, lo_b;
  logic [3:0]        cnt_a, cnt_b;
  logic              nl_a, nl_b, bz_a, bz_b, dn_a, dn_b;
  logic [1:0]        st_a, st_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  letter_typewriter #(.NUM_LETTERS(N), .CHAR_DELAY(4), .BLANK_CODE(5'd31)) u_a (
    .clk(clk), .resetN(resetN), .start(start), .skip(skip), .clear(clear),
    .letters_in(letters_in), .letters_out(lo_a), .revealed_cnt(cnt_a),
    .new_letter(nl_a), .busy(bz_a), .done(dn_a), .o_dbg_state(st_a)
  );

  letter_typewriter #(.NUM_LETTERS(N), .CHAR_DELAY(1), .BLANK_CODE(5'd31)) u_b (
    .clk(clk), .resetN(resetN), .start(start), .skip(skip), .clear(clear),
    .letters_in(letters_in), .letters_out(lo_b), .revealed_cnt(cnt_b),
    .new_letter(nl_b), .busy(bz_b), .done(dn_b), .o_dbg_state(st_b)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Revealed count is simply elapsed_cycles / CHAR_DELAY while typing.
  int          m_d[2] = '{4, 1};
  int          m_el[2];
  int          m_cnt[2];
  bit          m_typ[2], m_fin[2], m_pl[2];
  logic [4:0]  m_snap[2][N];

  task automatic model_step(input int k);
    int nc;
    if (resetN) begin
      m_typ[k] = 0; m_fin[k] = 0; m_cnt[k] = 0; m_el[k] = 0; m_pl[k] = 0;
      for (int i = 0; i < N; i++) m_snap[k][i] = 5'd0;
    end else if (clear) begin
      m_typ[k] = 0; m_fin[k] = 0; m_cnt[k] = 0; m_el[k] = 0; m_pl[k] = 0;
    end else if (m_typ[k] && skip) begin
      m_cnt[k] = N; m_typ[k] = 0; m_fin[k] = 1; m_pl[k] = 0;
    end else if (!m_typ[k] && start) begin
      for (int i = 0; i < N; i++) m_snap[k][i] = letters_in[i];
      m_el[k] = 0; m_cnt[k] = 0; m_typ[k] = 1; m_fin[k] = 0; m_pl[k] = 0;
    end else if (m_typ[k]) begin
      m_el[k]++;
      nc       = m_el[k] / m_d[k];
      m_pl[k]  = (nc != m_cnt[k]);
      m_cnt[k] = nc;
      if (m_cnt[k] == N) begin
        m_typ[k] = 0; m_fin[k] = 1;
      end
    end else begin
      m_pl[k] = 0;
    end
  endtask

  task automatic model_check(input int k);
    logic [N-1:0][4:0] exp_l;
    logic [63:0] exp_v, got_v;
    for (int i = 0; i < N; i++) exp_l[i] = (i < m_cnt[k]) ? m_snap[k][i] : 5'd31;
    exp_v = {7'd0, exp_l, 4'(m_cnt[k]), m_pl[k], m_typ[k], m_fin[k]};
    if (k == 0) got_v = {7'd0, lo_a, cnt_a, nl_a, bz_a, dn_a};
    else        got_v = {7'd0, lo_b, cnt_b, nl_b, bz_b, dn_b};
    chk(k == 0 ? "model_d4" : "model_d1", got_v, exp_v);
  endtask

  // ---------------- driver ----------------
  task automatic tick(input bit st, input bit sk, input bit cl, input bit rs);
    start = st; skip = sk; clear = cl; resetN = rs;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cyc++;
    model_check(0);
    model_check(1);
    start = 0; skip = 0; clear = 0; resetN = 0;
  endtask

  task automatic set_pat(input int pat);
    for (int i = 0; i < N; i++) begin
      if (pat == 1)      letters_in[i] = 5'd7;
      else if (pat == 2) letters_in[i] = 5'(i + 1);
    end
  endtask

  // ---------------- directed vector table (CHAR_DELAY=4 build) ----------------
  typedef struct {
    int gap;               // idle cycles before the vector edge
    bit st, sk, cl, rs;    // inputs on the vector edge
    int pat;               // 0 keep, 1 all 7s, 2 ascending 1..10
    int cnt;
    bit nl, bz, dn;
    int l0, l9;
  } vec_t;

  vec_t tbl[25];

  initial begin
    logic [N-1:0][4:0] blank;
    logic [63:0] g, e;

    tbl[0]  = '{0,  1,0,0,0, 2, 0,  0,1,0, 31,31}; // start T0
    tbl[1]  = '{2,  0,0,0,0, 0, 0,  0,1,0, 31,31}; // T0+3
    tbl[2]  = '{0,  0,0,0,0, 0, 1,  1,1,0,  1,31}; // T0+4 first reveal
    tbl[3]  = '{0,  0,0,0,0, 0, 1,  0,1,0,  1,31}; // T0+5
    tbl[4]  = '{0,  0,0,0,0, 1, 1,  0,1,0,  1,31}; // T0+6 letters_in -> 7s
    tbl[5]  = '{3,  1,0,0,0, 0, 2,  0,1,0,  1,31}; // T0+10 start ignored
    tbl[6]  = '{1,  0,0,0,0, 0, 3,  1,1,0,  1,31}; // T0+12
    tbl[7]  = '{27, 0,0,0,0, 0, 10, 1,0,1,  1,10}; // T0+40 last reveal
    tbl[8]  = '{0,  0,0,0,0, 0, 10, 0,0,1,  1,10}; // T0+41 hold
    tbl[9]  = '{0,  1,0,0,0, 2, 0,  0,1,0, 31,31}; // restart from DONE
    tbl[10] = '{8,  0,1,0,0, 0, 10, 0,0,1,  1,10}; // skip at T1+9
    tbl[11] = '{0,  0,0,0,0, 0, 10, 0,0,1,  1,10};
    tbl[12] = '{0,  1,0,0,0, 0, 0,  0,1,0, 31,31}; // restart
    tbl[13] = '{3,  0,1,0,0, 0, 10, 0,0,1,  1,10}; // skip on reveal edge
    tbl[14] = '{0,  1,0,0,0, 0, 0,  0,1,0, 31,31}; // restart
    tbl[15] = '{12, 0,0,1,0, 0, 0,  0,0,0, 31,31}; // clear at T3+13
    tbl[16] = '{3,  0,0,0,0, 0, 0,  0,0,0, 31,31}; // idle stays blank
    tbl[17] = '{0,  1,0,0,0, 0, 0,  0,1,0, 31,31}; // start from IDLE
    tbl[18] = '{16, 0,0,0,1, 0, 0,  0,0,0, 31,31}; // reset at T4+17
    tbl[19] = '{0,  1,0,0,0, 0, 0,  0,1,0, 31,31}; // start after reset
    tbl[20] = '{3,  0,0,0,0, 0, 1,  1,1,0,  1,31}; // T5+4
    tbl[21] = '{35, 0,0,0,0, 0, 10, 1,0,1,  1,10}; // T5+40
    tbl[22] = '{0,  0,1,0,0, 0, 10, 0,0,1,  1,10}; // skip in DONE ignored
    tbl[23] = '{0,  0,0,1,0, 0, 0,  0,0,0, 31,31}; // clear from DONE
    tbl[24] = '{0,  0,1,0,0, 0, 0,  0,0,0, 31,31}; // skip in IDLE ignored

    start = 0; skip = 0; clear = 0; resetN = 1;
    set_pat(2);
    for (int k = 0; k < 2; k++) begin
      m_el[k] = 0; m_cnt[k] = 0; m_typ[k] = 0; m_fin[k] = 0; m_pl[k] = 0;
      for (int i = 0; i < N; i++) m_snap[k][i] = 5'd0;
    end

    // Reset state
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    for (int i = 0; i < N; i++) blank[i] = 5'd31;
    chk("reset_letters", {14'd0, lo_a}, {14'd0, blank});
    chk("reset_status", {57'd0, cnt_a, nl_a, bz_a, dn_a}, 64'd0);

    // Directed table
    for (int r = 0; r < 25; r++) begin
      repeat (tbl[r].gap) tick(0, 0, 0, 0);
      set_pat(tbl[r].pat);
      tick(tbl[r].st, tbl[r].sk, tbl[r].cl, tbl[r].rs);
      g = {34'd0, 8'(cnt_a), nl_a, bz_a, dn_a, 8'(lo_a[0]), 8'(lo_a[9])};
      e = {34'd0, 8'(tbl[r].cnt), tbl[r].nl, tbl[r].bz, tbl[r].dn,
           8'(tbl[r].l0), 8'(tbl[r].l9)};
      chk($sformatf("tbl[%0d]", r), g, e);
    end

    // CHAR_DELAY=1 build: one reveal per edge, ten back-to-back pulses
    tick(0, 0, 0, 1);
    set_pat(2);
    tick(1, 0, 0, 0);
    for (int k = 1; k <= N; k++) begin
      tick(0, 0, 0, 0);
      g = {40'd0, 8'(cnt_b), nl_b, bz_b, dn_b, 5'd0, 8'(lo_b[k-1])};
      e = {40'd0, 8'(k), 1'b1, 1'(k != N), 1'(k == N), 5'd0, 8'(k)};
      chk($sformatf("d1_reveal%0d", k), g, e);
    end
    tick(0, 0, 0, 0);
    chk("d1_after", {57'd0, cnt_b, nl_b, bz_b, dn_b}, {57'd0, 4'd10, 1'b0, 1'b0, 1'b1});

    // Randomized phase, checked every cycle by the model
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) letters_in[i] = 5'($urandom_range(0, 31));
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
